eth2fifo: RTL and testbench



---
 rtl/eth2fifo_if.sv | 38 +++
 rtl/eth2fifo.sv | 115 +++++++++++
 tb/tb_eth2fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eth2fifo_if.sv
// FIFO entry types plus the Ethernet RX stream and FIFO write-side interfaces of eth2fifo.
// The master modport belongs to whichever side drives the data path.
package eth2fifo_pkg;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tkeep;
    logic [63:0] tdata;
    logic        tuser;
  } pcie_tlp64_t;

  typedef struct packed {
    logic        data_valid;
    pcie_tlp64_t tlp;
  } pcie_fifo64_tx_t;
endpackage

interface eth2fifo_eth_if;
  logic        eth_tvalid;
  logic        eth_tlast;
  logic [7:0]  eth_tkeep;
  logic [63:0] eth_tdata;
  logic        eth_tuser;

  modport master (output eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser);
  modport slave  (input  eth_tvalid, eth_tlast, eth_tkeep, eth_tdata, eth_tuser);
endinterface

interface eth2fifo_fifo_if;
  import eth2fifo_pkg::*;
  logic            prog_full;
  logic            wr_en;
  pcie_fifo64_tx_t din;
  logic            fifo_read_req;

  modport master (output wr_en, din, fifo_read_req, input prog_full);
  modport slave  (input  wr_en, din, fifo_read_req, output prog_full);
endinterface

// File: rtl/eth2fifo.sv
// NetTLP ingress: validates Eth/IPv4/UDP headers, strips 48 header bytes, writes byte-swapped TLP beats.
// Latency 1 cycle beat-to-write; no backpressure toward the MAC, prog_full sampled once per frame at beat 5.
module eth2fifo #(
  parameter logic [15:0] UDP_PORT_BASE = 16'h3000,
  parameter logic [15:0] UDP_PORT_MASK = 16'hFFF0
) (
  input  logic                   eth_clk,
  input  logic                   eth_rst,
  eth2fifo_eth_if.slave          eth,
  eth2fifo_fifo_if.master        fifo,
  output logic [31:0]            stat_rx_pkts,
  output logic [31:0]            stat_drop_pkts,
  output logic [31:0]            stat_bad_fcs
);
  import eth2fifo_pkg::*;

  typedef enum logic [1:0] {HDR, PASS, DROP} state_t;

  state_t          state_q;
  logic [2:0]      beat_q;
  logic            ipv4_ok_q, udp_ok_q, port_ok_q;
  logic            wr_en_q, read_req_q;
  pcie_fifo64_tx_t din_q, din_d;
  logic [31:0]     rx_pkts_q, drop_pkts_q, bad_fcs_q;

  logic            ipv4_hit, udp_hit, port_hit;
  logic [15:0]     dport;

  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] k);
    return {k[0], k[1], k[2], k[3]};
  endfunction

  // Per-beat header field matches; only meaningful on the beat that carries the field.
  assign dport    = {eth.eth_tdata[39:32], eth.eth_tdata[47:40]};
  assign ipv4_hit = (eth.eth_tdata[39:32] == 8'h08) && (eth.eth_tdata[47:40] == 8'h00) &&
                    (eth.eth_tdata[55:48] == 8'h45);
  assign udp_hit  = (eth.eth_tdata[63:56] == 8'h11);
  assign port_hit = ((dport & UDP_PORT_MASK) == (UDP_PORT_BASE & UDP_PORT_MASK));

  always_comb begin
    din_d                 = '0;
    din_d.data_valid      = 1'b1;
    din_d.tlp.tvalid      = 1'b1;
    din_d.tlp.tlast       = eth.eth_tlast;
    din_d.tlp.tuser       = 1'b0;
    din_d.tlp.tdata       = {bswap32(eth.eth_tdata[63:32]), bswap32(eth.eth_tdata[31:0])};
    din_d.tlp.tkeep       = {rev4(eth.eth_tkeep[7:4]), rev4(eth.eth_tkeep[3:0])};
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      state_q     <= HDR;
      beat_q      <= '0;
      ipv4_ok_q   <= 1'b0;
      udp_ok_q    <= 1'b0;
      port_ok_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      read_req_q  <= 1'b0;
      din_q       <= '0;
      rx_pkts_q   <= '0;
      drop_pkts_q <= '0;
      bad_fcs_q   <= '0;
    end else begin
      wr_en_q    <= 1'b0;
      read_req_q <= 1'b0;
      if (eth.eth_tvalid) begin
        case (state_q)
          HDR: begin
            if (beat_q == 3'd1) ipv4_ok_q <= ipv4_hit;
            if (beat_q == 3'd2) udp_ok_q  <= udp_hit;
            if (beat_q == 3'd4) port_ok_q <= port_hit;
            if (eth.eth_tlast) begin
              drop_pkts_q <= drop_pkts_q + 32'd1;
              beat_q      <= '0;
            end else if (beat_q == 3'd5) begin
              // Forward/drop is decided here so a dropped frame never reaches the FIFO.
              beat_q  <= '0;
              state_q <= (ipv4_ok_q && udp_ok_q && port_ok_q && !fifo.prog_full) ? PASS : DROP;
            end else begin
              beat_q <= beat_q + 3'd1;
            end
          end
          PASS: begin
            wr_en_q <= 1'b1;
            din_q   <= din_d;
            if (eth.eth_tlast) begin
              read_req_q <= 1'b1;
              rx_pkts_q  <= rx_pkts_q + 32'd1;
              if (eth.eth_tuser) bad_fcs_q <= bad_fcs_q + 32'd1;
              state_q    <= HDR;
            end
          end
          DROP: begin
            if (eth.eth_tlast) begin
              drop_pkts_q <= drop_pkts_q + 32'd1;
              state_q     <= HDR;
            end
          end
          default: state_q <= HDR;
        endcase
      end
    end
  end

  assign fifo.wr_en         = wr_en_q;
  assign fifo.din           = din_q;
  assign fifo.fifo_read_req = read_req_q;
  assign stat_rx_pkts       = rx_pkts_q;
  assign stat_drop_pkts     = drop_pkts_q;
  assign stat_bad_fcs       = bad_fcs_q;
endmodule

// File: tb/tb_eth2fifo.sv
// Directed frames into eth2fifo; expected FIFO entries are queued at stimulus time and popped by a monitor.
module tb_eth2fifo;
  import eth2fifo_pkg::*;

  logic eth_clk = 1'b0;
  logic eth_rst = 1'b1;
  always #5 eth_clk = ~eth_clk;

  eth2fifo_eth_if  eth_bus ();
  eth2fifo_fifo_if fifo_bus ();
  logic [31:0] stat_rx_pkts, stat_drop_pkts, stat_bad_fcs;

  eth2fifo #(.UDP_PORT_BASE(16'h3000), .UDP_PORT_MASK(16'hFFF0)) dut (
    .eth_clk        (eth_clk),
    .eth_rst        (eth_rst),
    .eth            (eth_bus),
    .fifo           (fifo_bus),
    .stat_rx_pkts   (stat_rx_pkts),
    .stat_drop_pkts (stat_drop_pkts),
    .stat_bad_fcs   (stat_bad_fcs)
  );

  typedef struct {
    pcie_fifo64_tx_t din;
    logic            rrq;
    int              cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [7:0]  fb[$];
  logic [31:0] tlp_dw[$];

  always @(posedge eth_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest expected entry, including its cycle.
  always @(negedge eth_clk) begin
    if (!eth_rst) begin
      if (fifo_bus.wr_en) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got din %0h expected no write", fifo_bus.din);
        end else begin
          mon_e = exp_q.pop_front();
          chk("din", fifo_bus.din, mon_e.din);
          chk("read_req", fifo_bus.fifo_read_req, mon_e.rrq);
          chk("write_cycle", cyc, mon_e.cyc);
        end
      end else begin
        chk("idle_read_req", fifo_bus.fifo_read_req, 0);
      end
    end
  end

  task automatic drive_idle(input logic pf);
    eth_bus.eth_tvalid = 1'b0;
    eth_bus.eth_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    eth_bus.eth_tkeep  = 8'hFF;
    eth_bus.eth_tlast  = 1'b1;
    eth_bus.eth_tuser  = 1'b1;
    fifo_bus.prog_full = pf;
  endtask

  task automatic build_frame(input logic [15:0] etype, input logic [7:0] proto, input logic [15:0] dport);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 6; i++) fb.push_back(8'h20 + 8'(i));
    fb.push_back(etype[15:8]); fb.push_back(etype[7:0]);
    fb.push_back(8'h45); fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h3C);
    fb.push_back(8'h00); fb.push_back(8'h00); fb.push_back(8'h40); fb.push_back(8'h00);
    fb.push_back(8'h40); fb.push_back(proto); fb.push_back(8'h00); fb.push_back(8'h00);
    fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h00); fb.push_back(8'h01);
    fb.push_back(8'hC0); fb.push_back(8'hA8); fb.push_back(8'h00); fb.push_back(8'h02);
    fb.push_back(8'h12); fb.push_back(8'h34); fb.push_back(dport[15:8]); fb.push_back(dport[7:0]);
    fb.push_back(8'h00); fb.push_back(8'h28); fb.push_back(8'h00); fb.push_back(8'h00);
    fb.push_back(8'h00); fb.push_back(8'h07); fb.push_back(8'hDE); fb.push_back(8'hAD);
    fb.push_back(8'hBE); fb.push_back(8'hEF);
    foreach (tlp_dw[i]) begin
      fb.push_back(tlp_dw[i][31:24]); fb.push_back(tlp_dw[i][23:16]);
      fb.push_back(tlp_dw[i][15:8]);  fb.push_back(tlp_dw[i][7:0]);
    end
  endtask

  // Drives the frame in fb; for forwarded frames the expected entries come from tlp_dw in PCIe DW order.
  task automatic send_frame(input bit pass, input bit gaps, input bit tuser, input bit pf5,
                            input bit pfpass, input int rst_beat, input int trunc);
    int nb, g, i;
    bit was_rst, last;
    logic [63:0] d;
    logic [7:0] k;
    exp_t ex;
    nb = (fb.size() + 7) / 8;
    if (trunc > 0) nb = trunc;
    was_rst = 0;
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge eth_clk);
          drive_idle(pfpass);
        end
      end
      @(negedge eth_clk);
      if (b == rst_beat) begin
        drive_idle(1'b0);
        #2 eth_rst = 1'b1;
        #1;
        chk("rst_wr_en", fifo_bus.wr_en, 0);
        chk("rst_din", fifo_bus.din, 0);
        chk("rst_read_req", fifo_bus.fifo_read_req, 0);
        chk("rst_stat_rx", stat_rx_pkts, 0);
        @(negedge eth_clk);
        eth_rst = 1'b0;
        was_rst = 1;
      end else begin
        d = '0;
        k = '0;
        for (int n = 0; n < 8; n++) begin
          if (8 * b + n < fb.size()) begin
            d[8*n +: 8] = fb[8*b+n];
            k[n] = 1'b1;
          end
        end
        last = (b == nb - 1);
        eth_bus.eth_tvalid = 1'b1;
        eth_bus.eth_tdata  = d;
        eth_bus.eth_tkeep  = k;
        eth_bus.eth_tlast  = last;
        eth_bus.eth_tuser  = last ? tuser : 1'b0;
        fifo_bus.prog_full = (b == 5) ? pf5 : ((b > 5) ? pfpass : 1'b0);
        if (pass && !was_rst && b >= 6) begin
          i = b - 6;
          ex.din = '0;
          ex.din.data_valid = 1'b1;
          ex.din.tlp.tvalid = 1'b1;
          ex.din.tlp.tlast  = last;
          ex.din.tlp.tdata[31:0] = tlp_dw[2*i];
          if (2 * i + 1 < tlp_dw.size()) begin
            ex.din.tlp.tdata[63:32] = tlp_dw[2*i+1];
            ex.din.tlp.tkeep = 8'hFF;
          end else begin
            ex.din.tlp.tkeep = 8'h0F;
          end
          ex.rrq = last;
          ex.cyc = cyc + 1;
          exp_q.push_back(ex);
        end
      end
    end
  endtask

  task automatic check_stats(input int rx, input int drop, input int fcs);
    @(negedge eth_clk);
    drive_idle(1'b0);
    repeat (2) @(negedge eth_clk);
    chk("stat_rx_pkts", stat_rx_pkts, rx);
    chk("stat_drop_pkts", stat_drop_pkts, drop);
    chk("stat_bad_fcs", stat_bad_fcs, fcs);
  endtask

  task automatic load_mrd();
    tlp_dw = '{32'h0000_0001, 32'h0100_000F, 32'h0000_1000};
  endtask

  initial begin
    drive_idle(1'b0);
    eth_rst = 1'b1;
    repeat (3) @(negedge eth_clk);
    chk("reset_wr_en", fifo_bus.wr_en, 0);
    chk("reset_din", fifo_bus.din, 0);
    chk("reset_read_req", fifo_bus.fifo_read_req, 0);
    chk("reset_stat_rx", stat_rx_pkts, 0);
    chk("reset_stat_drop", stat_drop_pkts, 0);
    chk("reset_stat_fcs", stat_bad_fcs, 0);
    eth_rst = 1'b0;
    repeat (2) @(negedge eth_clk);

    // Valid 3DW MRd, dport inside the masked range.
    load_mrd();
    build_frame(16'h0800, 8'h11, 16'h3001);
    send_frame(1, 0, 0, 0, 0, -1, 0);
    check_stats(1, 0, 0);

    // Header rejects: IPv6 EtherType, TCP, out-of-range port.
    build_frame(16'h86DD, 8'h11, 16'h3001);
    send_frame(0, 0, 0, 0, 0, -1, 0);
    build_frame(16'h0800, 8'h06, 16'h3001);
    send_frame(0, 0, 0, 0, 0, -1, 0);
    build_frame(16'h0800, 8'h11, 16'h4000);
    send_frame(0, 0, 0, 0, 0, -1, 0);
    check_stats(1, 3, 0);

    // prog_full at beat 5 drops; prog_full during payload does not.
    build_frame(16'h0800, 8'h11, 16'h300F);
    send_frame(0, 0, 0, 1, 0, -1, 0);
    check_stats(1, 4, 0);
    send_frame(1, 0, 0, 0, 1, -1, 0);
    check_stats(2, 4, 0);

    // Runt ending at beat 4, then a 3DW MWr with 2 payload DWs back-to-back.
    build_frame(16'h0800, 8'h11, 16'h3000);
    send_frame(0, 0, 0, 0, 0, -1, 5);
    tlp_dw = '{32'h4000_0002, 32'h0100_00FF, 32'h0000_2000, 32'hCAFE_0001, 32'hCAFE_0002};
    build_frame(16'h0800, 8'h11, 16'h3000);
    send_frame(1, 0, 0, 0, 0, -1, 0);
    check_stats(3, 5, 0);

    // Gapped valid frame with bad FCS at tlast.
    load_mrd();
    build_frame(16'h0800, 8'h11, 16'h3001);
    send_frame(1, 1, 1, 0, 0, -1, 0);
    check_stats(4, 5, 1);

    // Reset at beat 7 of a 4DW MWr with 16 payload DWs; remainder must be dropped.
    tlp_dw = '{32'h6000_0010, 32'h0100_00FF, 32'h0000_0001, 32'h0000_3000};
    for (int i = 0; i < 16; i++) tlp_dw.push_back(32'hA5A5_0000 + 32'(i));
    build_frame(16'h0800, 8'h11, 16'h3002);
    send_frame(1, 0, 0, 0, 0, 7, 0);
    check_stats(0, 1, 0);
    load_mrd();
    build_frame(16'h0800, 8'h11, 16'h3001);
    send_frame(1, 0, 0, 0, 0, -1, 0);
    check_stats(1, 1, 0);

    repeat (3) @(negedge eth_clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
